// File: rtl/env_step_driver_if.sv
// env_step_driver_if: transition channel from the environment stepper to the Dyna-Q learner
// valid/ready handshake carrying one (state, action, reward, next_state, terminal) transition
// master: stepper drives valid and payload, samples ready; slave: learner side
interface env_step_driver_if #(
    parameter int LOCATION_LENGTH = 32,
    parameter int REWARD_LENGTH   = 11
);
    logic                       valid;
    logic                       ready;
    logic [LOCATION_LENGTH-1:0] state;
    logic [1:0]                 action;
    logic [REWARD_LENGTH-1:0]   reward;
    logic [LOCATION_LENGTH-1:0] next_state;
    logic                       terminal;
    modport master(output valid, state, action, reward, next_state, terminal, input ready);
    modport slave(input valid, state, action, reward, next_state, terminal, output ready);
endinterface

// File: rtl/env_step_driver.sv
// env_step_driver: epsilon-greedy agent stepper for the 5x5 grid environment, emits transitions and sequences episodes
// clk/reset (sync, active-low); start, epsilon, policy_valid/policy_action from the learner;
// env_location/env_action to and env_reward/env_next_location from the environment;
// tr (master) transition channel; episode_done pulse, episode_count, busy status
module env_step_driver #(
    parameter int          LOCATION_LENGTH = 32,
    parameter int          REWARD_LENGTH   = 11,
    parameter int          START_LOCATION  = 0,
    parameter int          MAX_STEPS       = 64,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 epsilon,
    input  logic                       policy_valid,
    input  logic [1:0]                 policy_action,
    output logic [LOCATION_LENGTH-1:0] env_location,
    output logic [1:0]                 env_action,
    input  logic [REWARD_LENGTH-1:0]   env_reward,
    input  logic [LOCATION_LENGTH-1:0] env_next_location,
    env_step_driver_if.master          tr,
    output logic                       episode_done,
    output logic [15:0]                episode_count,
    output logic                       busy
);
    localparam int STEP_W = $clog2(MAX_STEPS) + 1;
    localparam logic [2:0] IDLE = 3'd0, DECIDE = 3'd1, SAMPLE = 3'd2, EMIT = 3'd3, DONE = 3'd4;
    localparam logic [REWARD_LENGTH-1:0] TREASURE = {1'b0, {(REWARD_LENGTH-1){1'b1}}};
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
    localparam logic [LOCATION_LENGTH-1:0] HOME = LOCATION_LENGTH'(START_LOCATION);
    logic [2:0]        state;
    logic [STEP_W-1:0] step;
    logic [15:0]       lfsr;
    logic [1:0]        choice;
    // explore with a random direction when the low LFSR byte falls under epsilon
    assign choice       = (lfsr[7:0] < epsilon) ? lfsr[9:8] : policy_action;
    assign tr.valid     = state == EMIT;
    assign busy         = state != IDLE;
    assign episode_done = state == DONE;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            step          <= '0;
            lfsr          <= LFSR_SEED;
            env_location  <= HOME;
            env_action    <= 2'd0;
            episode_count <= 16'd0;
            tr.state      <= '0;
            tr.action     <= 2'd0;
            tr.reward     <= '0;
            tr.next_state <= '0;
            tr.terminal   <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            case (state)
                IDLE: if (start) begin
                    env_location <= HOME;
                    step         <= '0;
                    state        <= DECIDE;
                end
                DECIDE: if (policy_valid) begin
                    env_action <= choice;
                    state      <= SAMPLE;
                end
                SAMPLE: begin
                    tr.state      <= env_location;
                    tr.action     <= env_action;
                    tr.reward     <= env_reward;
                    tr.next_state <= env_next_location;
                    tr.terminal   <= (env_reward == TREASURE) | (step == LAST_STEP);
                    state         <= EMIT;
                end
                EMIT: if (tr.ready) begin
                    step         <= step + 1'b1;
                    env_location <= tr.next_state;
                    state        <= tr.terminal ? DONE : DECIDE;
                end
                DONE: begin
                    episode_count <= episode_count + {15'd0, episode_count != 16'hFFFF};
                    env_location  <= HOME;
                    step          <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_env_step_driver.sv
// tb_env_step_driver: grid-environment bench with a transaction-level model of the stepper
module tb_env_step_driver;
    localparam int MAXS = 4;
    typedef struct packed {
        logic [31:0] s;
        logic [1:0]  a;
        logic [10:0] r;
        logic [31:0] ns;
        logic        t;
    } tr_t;
    logic        clk, reset, start, policy_valid;
    logic [7:0]  epsilon;
    logic [1:0]  policy_action, env_action;
    logic [31:0] env_location, env_next_location, treasure;
    logic [10:0] env_reward;
    logic        episode_done, busy;
    logic [15:0] episode_count;
    int          n_vec = 0, n_err = 0;
    tr_t         hs[$];
    env_step_driver_if #(.LOCATION_LENGTH(32), .REWARD_LENGTH(11)) tr_if();
    env_step_driver #(.LOCATION_LENGTH(32), .REWARD_LENGTH(11), .START_LOCATION(0),
                      .MAX_STEPS(MAXS), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .epsilon(epsilon),
        .policy_valid(policy_valid), .policy_action(policy_action),
        .env_location(env_location), .env_action(env_action),
        .env_reward(env_reward), .env_next_location(env_next_location),
        .tr(tr_if), .episode_done(episode_done), .episode_count(episode_count), .busy(busy));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] env_ns(input logic [31:0] l, input logic [1:0] a);
        int c, r;
        c = int'(l % 32'd5);
        r = int'(l / 32'd5);
        if (a == 2'd0 && c > 0) return l - 32'd1;
        if (a == 2'd1 && r > 0) return l - 32'd5;
        if (a == 2'd2 && c < 4) return l + 32'd1;
        if (a == 2'd3 && r < 4) return l + 32'd5;
        return l;
    endfunction
    function automatic logic [10:0] env_rw(input logic [31:0] l, input logic [1:0] a, input logic [31:0] t);
        logic [31:0] n;
        n = env_ns(l, a);
        return (n == l) ? 11'h7FE : (n == t) ? 11'h3FF : 11'h000;
    endfunction
    assign env_next_location = env_ns(env_location, env_action);
    assign env_reward        = env_rw(env_location, env_action, treasure);
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    int          m_ph, m_step, m_cnt;
    logic [31:0] m_loc;
    logic [1:0]  m_act;
    logic [15:0] m_lfsr;
    logic [10:0] m_r;
    tr_t         m_tr;
    bit          mvalid = 0;
    always @(negedge clk) begin
        if (mvalid) begin
            chk("busy", 64'(busy), 64'(m_ph != 0));
            chk("tr_valid", 64'(tr_if.valid), 64'(m_ph == 3));
            chk("episode_done", 64'(episode_done), 64'(m_ph == 4));
            chk("episode_count", 64'(episode_count), 64'(m_cnt));
            chk("env_location", 64'(env_location), 64'(m_loc));
            chk("env_action", 64'(env_action), 64'(m_act));
            chk("tr_state", 64'(tr_if.state), 64'(m_tr.s));
            chk("tr_action", 64'(tr_if.action), 64'(m_tr.a));
            chk("tr_reward", 64'(tr_if.reward), 64'(m_tr.r));
            chk("tr_next_state", 64'(tr_if.next_state), 64'(m_tr.ns));
            chk("tr_terminal", 64'(tr_if.terminal), 64'(m_tr.t));
            if (tr_if.valid && tr_if.ready)
                hs.push_back({tr_if.state, tr_if.action, tr_if.reward, tr_if.next_state, tr_if.terminal});
        end
        if (!reset) begin
            m_ph = 0; m_step = 0; m_cnt = 0; m_loc = 0; m_act = 0; m_tr = '0;
            m_lfsr = 16'hACE1;
            mvalid = 1;
        end else if (mvalid) begin
            case (m_ph)
                0: if (start) begin m_loc = 0; m_step = 0; m_ph = 1; end
                1: if (policy_valid) begin
                    m_act = (m_lfsr[7:0] < epsilon) ? m_lfsr[9:8] : policy_action;
                    m_ph = 2;
                end
                2: begin
                    m_r = env_rw(m_loc, m_act, treasure);
                    m_tr.s = m_loc; m_tr.a = m_act; m_tr.r = m_r;
                    m_tr.ns = env_ns(m_loc, m_act);
                    m_tr.t = (m_r == 11'h3FF) || (m_step == MAXS - 1);
                    m_ph = 3;
                end
                3: if (tr_if.ready) begin
                    m_step++;
                    m_loc = m_tr.ns;
                    m_ph = m_tr.t ? 4 : 1;
                end
                default: begin
                    m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                    m_loc = 0; m_step = 0; m_ph = 0;
                end
            endcase
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end
    initial begin
        int ac[4];
        reset = 0; start = 0; epsilon = 0; policy_valid = 1; policy_action = 2;
        tr_if.ready = 0; treasure = 3;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(tr_if.valid), 64'd0);
        chk("rst_loc", 64'(env_location), 64'd0);
        chk("rst_count", 64'(episode_count), 64'd0);
        chk("rst_done", 64'(episode_done), 64'd0);
        reset = 1; tick();
        start = 1; tick(); start = 0;
        tick();
        chk("lat_early", 64'(tr_if.valid), 64'd0);
        tick();
        chk("lat_valid", 64'(tr_if.valid), 64'd1);
        chk("t1_state", 64'(tr_if.state), 64'd0);
        chk("t1_action", 64'(tr_if.action), 64'd2);
        chk("t1_reward", 64'(tr_if.reward), 64'd0);
        chk("t1_next", 64'(tr_if.next_state), 64'd1);
        chk("t1_term", 64'(tr_if.terminal), 64'd0);
        repeat (5) tick();
        chk("bp_valid", 64'(tr_if.valid), 64'd1);
        chk("bp_state", 64'(tr_if.state), 64'd0);
        chk("bp_loc", 64'(env_location), 64'd0);
        tr_if.ready = 1; tick(); tr_if.ready = 0;
        chk("hs_drop", 64'(tr_if.valid), 64'd0);
        tick(); tick();
        chk("t2_valid", 64'(tr_if.valid), 64'd1);
        chk("t2_state", 64'(tr_if.state), 64'd1);
        chk("t2_next", 64'(tr_if.next_state), 64'd2);
        tr_if.ready = 1; tick(); tick(); tick();
        chk("t3_valid", 64'(tr_if.valid), 64'd1);
        chk("t3_state", 64'(tr_if.state), 64'd2);
        chk("t3_next", 64'(tr_if.next_state), 64'd3);
        chk("t3_reward", 64'(tr_if.reward), 64'h3FF);
        chk("t3_term", 64'(tr_if.terminal), 64'd1);
        tick();
        chk("done_pulse", 64'(episode_done), 64'd1);
        tick();
        chk("done_low", 64'(episode_done), 64'd0);
        chk("count_1", 64'(episode_count), 64'd1);
        chk("home_loc", 64'(env_location), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        treasure = 25; policy_action = 0; hs.delete();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 60 && !episode_done; i++) begin
            policy_valid = ~policy_valid;
            start = (i == 5);
            tick();
        end
        start = 0; policy_valid = 1;
        chk("lim_done", 64'(episode_done), 64'd1);
        chk("lim_count", 64'(hs.size()), 64'd4);
        foreach (hs[i]) begin
            chk("lim_state", 64'(hs[i].s), 64'd0);
            chk("lim_next", 64'(hs[i].ns), 64'd0);
            chk("lim_reward", 64'(hs[i].r), 64'h7FE);
            chk("lim_term", 64'(hs[i].t), 64'(i == 3));
        end
        tick();
        chk("count_2", 64'(episode_count), 64'd2);
        epsilon = 255; hs.delete(); start = 1;
        for (int i = 0; i < 4000 && hs.size() < 200; i++) tick();
        chk("rand_steps", 64'(hs.size() >= 200), 64'd1);
        foreach (hs[i]) ac[hs[i].a]++;
        for (int k = 0; k < 4; k++) chk("act_spread", 64'(ac[k] >= 20), 64'd1);
        for (int i = 0; i < 10 && !tr_if.valid; i++) tick();
        chk("emit_seen", 64'(tr_if.valid), 64'd1);
        reset = 0; tick();
        chk("abort_valid", 64'(tr_if.valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        start = 0; reset = 1;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
